// File: rtl/sao_bo_stat_ctrl.sv
// ---------------------------------------------------------------------------
// sao_bo_stat_ctrl
//
// Purpose:
//   Sequencer for the SAO band-offset statistics reduce stage. For one CTB it
//   walks the components Y, Cb, Cr (or Y only when chroma is disabled). For
//   each component it gates pixel groups from the reconstruction buffer into
//   the reduce datapath and then issues the collect. It holds cIdx until that
//   component's cand_bo has been written, and pulses done at the end of the
//   CTB.
//
// Ports:
//   clk, arst_n        clock, asynchronous active-low reset
//   start              pulse, begins one CTB (accepted only while idle)
//   chroma_en          sampled with start; 0 = luma-only CTB
//   abort              synchronous cancel of the CTB in progress
//   pix_valid          source presents a pixel group this cycle
//   pix_ready          group consumed this cycle
//   en_o               reduce-stage clock enable
//   stat_rst_n         reduce-stage synchronous clear, active low
//   isWorking_stat     reduce "working" flag
//   is_bo_pre          reduce "accumulate this group" flag
//   not_end_pre_stage  reduce flag, low = issue collect
//   cIdx               component index 0/1/2
//   busy               CTB in progress
//   done               one-cycle pulse when the last cand_bo is written
// ---------------------------------------------------------------------------
module sao_bo_stat_ctrl #(
    parameter int n_pix     = 4,
    parameter int N_GRP_Y   = 256,
    parameter int N_GRP_C   = 128,
    parameter int FLUSH_LEN = 3
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       start,
    input  logic       chroma_en,
    input  logic       abort,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       en_o,
    output logic       stat_rst_n,
    output logic       isWorking_stat,
    output logic       is_bo_pre,
    output logic       not_end_pre_stage,
    output logic [1:0] cIdx,
    output logic       busy,
    output logic       done
);

    // The reduce adder tree only exists for 4- or 8-pixel groups; any other
    // group width is never started, so the block stays idle.
    localparam logic       CFG_OK     = (n_pix == 4) || (n_pix == 8);
    localparam logic [8:0] GRP_LAST_Y = 9'(N_GRP_Y - 1);
    localparam logic [8:0] GRP_LAST_C = 9'(N_GRP_C - 1);
    localparam logic [1:0] FL_LAST    = 2'(FLUSH_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACC,
        S_FLUSH,
        S_DONE,
        S_CLR_AB
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] grp_cnt_q, grp_cnt_d;
    logic [1:0] fl_cnt_q, fl_cnt_d;
    logic [1:0] cidx_q, cidx_d;
    logic       chroma_q, chroma_d;
    logic [8:0] grp_last;

    // State and counter registers; reset also returns cIdx to luma.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= S_IDLE;
            grp_cnt_q <= '0;
            fl_cnt_q  <= '0;
            cidx_q    <= '0;
            chroma_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_cnt_q <= grp_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            cidx_q    <= cidx_d;
            chroma_q  <= chroma_d;
        end
    end

    assign cIdx     = cidx_q;
    assign grp_last = (cidx_q == 2'd0) ? GRP_LAST_Y : GRP_LAST_C;

    // Next-state and output decode. Outputs depend on state only, except
    // en_o in ACC, which follows pix_valid so that a stall freezes the whole
    // reduce pipe.
    always_comb begin
        state_d           = state_q;
        grp_cnt_d         = grp_cnt_q;
        fl_cnt_d          = fl_cnt_q;
        cidx_d            = cidx_q;
        chroma_d          = chroma_q;
        pix_ready         = 1'b0;
        en_o              = 1'b0;
        stat_rst_n        = 1'b1;
        isWorking_stat    = 1'b0;
        is_bo_pre         = 1'b0;
        not_end_pre_stage = 1'b1;
        busy              = 1'b1;
        done              = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort && CFG_OK) begin
                    state_d   = S_CLR;
                    chroma_d  = chroma_en;
                    cidx_d    = 2'd0;
                    grp_cnt_d = '0;
                    fl_cnt_d  = '0;
                end
            end

            S_CLR: begin
                stat_rst_n = 1'b0;
                state_d    = S_ACC;
            end

            S_ACC: begin
                isWorking_stat = 1'b1;
                is_bo_pre      = 1'b1;
                pix_ready      = 1'b1;
                en_o           = pix_valid;
                if (pix_valid) begin
                    if (grp_cnt_q == grp_last) begin
                        grp_cnt_d = '0;
                        fl_cnt_d  = '0;
                        state_d   = S_FLUSH;
                    end else begin
                        grp_cnt_d = grp_cnt_q + 9'd1;
                    end
                end
            end

            // First flush cycle issues the collect; the remaining cycles let
            // the result drain to cand_bo while cIdx is held. The collect
            // also zeroes the sum, so the next component needs no CLR.
            S_FLUSH: begin
                en_o = 1'b1;
                if (fl_cnt_q == 2'd0) begin
                    isWorking_stat    = 1'b1;
                    not_end_pre_stage = 1'b0;
                end
                if (fl_cnt_q == FL_LAST) begin
                    fl_cnt_d = '0;
                    if ((cidx_q == 2'd2) || ((cidx_q == 2'd0) && !chroma_q)) begin
                        state_d = S_DONE;
                    end else begin
                        cidx_d  = cidx_q + 2'd1;
                        state_d = S_ACC;
                    end
                end else begin
                    fl_cnt_d = fl_cnt_q + 2'd1;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_CLR_AB: begin
                stat_rst_n = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every other transition once a CTB is underway.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_CLR_AB;
            grp_cnt_d = '0;
            fl_cnt_d  = '0;
            cidx_d    = 2'd0;
        end
    end

endmodule
